// File: rtl/clock_cfg_pkg.sv
// -----------------------------------------------------------------------------
// clock_cfg_pkg
// Shared widths, sweep FSM state encoding and clamp helpers for the clock
// generator configuration controller (clock_sweep_ctrl).
// No ports; imported by clock_sweep_ctrl and dwell_timer.
// -----------------------------------------------------------------------------
package clock_cfg_pkg;

  localparam int PERIOD_W = 12;
  localparam int DUTY_W   = 4;
  localparam int NCH      = 4;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_STEP  = 2'd2,
    S_DONE  = 2'd3
  } sweep_state_e;

  // A zero period is meaningless to the generator; treat it as 1.
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] period);
    return (period == '0) ? PERIOD_W'(1) : period;
  endfunction

  // Duty may not exceed the (already clamped) period; compared at full
  // period width so large periods never truncate the comparison.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0]   duty,
                                                   input logic [PERIOD_W-1:0] period);
    logic [PERIOD_W-1:0] duty_ext;
    duty_ext = {{(PERIOD_W-DUTY_W){1'b0}}, duty};
    return (duty_ext > period) ? period[DUTY_W-1:0] : duty;
  endfunction

  // Highest duty a sweep may reach: the period, capped at the 4-bit maximum.
  function automatic logic [DUTY_W-1:0] sweep_end(input logic [PERIOD_W-1:0] period);
    return (period > PERIOD_W'(DUTY_MAX)) ? DUTY_MAX : period[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/clock_sweep_ctrl_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Loadable down-counter with a zero flag, used to time each sweep step.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   dec        : decrement by one, saturating at zero
//   load_val   : value to load
//   zero       : count is zero (registered state decode)
// -----------------------------------------------------------------------------
module dwell_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/clock_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// clock_sweep_ctrl
// Configuration controller for the four-channel programmable clock generator.
// Accepts period/duty commands on a valid/ready handshake and holds the
// generator's period/duty inputs in registers. With CLOCK_SWEEP_EN defined it
// can also step one channel's duty from a start value up to min(15, period),
// holding each value for DWELL cycles. Without CLOCK_SWEEP_EN every command is
// a static write and the sweep outputs are tied off.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    : command handshake (ready only when idle)
//   cmd_ch, cmd_period,
//   cmd_duty, cmd_sweep      : command payload
//   abort                    : stop an active sweep, keeping the current duty
//   period0..3, duty0..3     : registered outputs to the generator
//   sweep_busy, sweep_done   : sweep active / one-cycle normal-completion pulse
// -----------------------------------------------------------------------------
module clock_sweep_ctrl
  import clock_cfg_pkg::*;
#(
  parameter int DWELL        = 50,
  parameter int RESET_PERIOD = 3,
  parameter int RESET_DUTY   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ch,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic [DUTY_W-1:0]   cmd_duty,
  input  logic                cmd_sweep,
  input  logic                abort,
  output logic [PERIOD_W-1:0] period0,
  output logic [PERIOD_W-1:0] period1,
  output logic [PERIOD_W-1:0] period2,
  output logic [PERIOD_W-1:0] period3,
  output logic [DUTY_W-1:0]   duty0,
  output logic [DUTY_W-1:0]   duty1,
  output logic [DUTY_W-1:0]   duty2,
  output logic [DUTY_W-1:0]   duty3,
  output logic                sweep_busy,
  output logic                sweep_done
);

  logic [PERIOD_W-1:0] period_q [NCH];
  logic [PERIOD_W-1:0] period_d [NCH];
  logic [DUTY_W-1:0]   duty_q   [NCH];
  logic [DUTY_W-1:0]   duty_d   [NCH];

  logic [PERIOD_W-1:0] p_clamp;
  logic [DUTY_W-1:0]   d_clamp;

  always_comb begin
    p_clamp = clamp_period(cmd_period);
    d_clamp = clamp_duty(cmd_duty, p_clamp);
  end

`ifdef CLOCK_SWEEP_EN
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

  sweep_state_e      state_q, state_d;
  logic [1:0]        ch_q, ch_d;
  logic [DUTY_W-1:0] end_q, end_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              tmr_load, tmr_dec, tmr_zero;

  dwell_timer #(.W(CNT_W)) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (DWELL_LOAD),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    end_d    = end_q;
    period_d = period_q;
    duty_d   = duty_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          period_d[cmd_ch] = p_clamp;
          duty_d[cmd_ch]   = d_clamp;
          if (cmd_sweep) begin
            ch_d     = cmd_ch;
            end_d    = sweep_end(p_clamp);
            tmr_load = 1'b1;
            state_d  = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (tmr_zero) begin
          state_d = (duty_q[ch_q] == end_q) ? S_DONE : S_STEP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_STEP: begin
        // Abort takes precedence: the pending increment is dropped.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          duty_d[ch_q] = duty_q[ch_q] + 1'b1;
          tmr_load     = 1'b1;
          state_d      = S_DWELL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the next state.
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      end_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      end_q   <= end_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign sweep_busy = busy_q;
  assign sweep_done = done_q;
`else
  always_comb begin
    period_d = period_q;
    duty_d   = duty_q;
    if (cmd_valid) begin
      period_d[cmd_ch] = p_clamp;
      duty_d[cmd_ch]   = d_clamp;
    end
  end

  // Sweep controls have no function in this build.
  logic unused_sweep_inputs;
  assign unused_sweep_inputs = ^{abort, cmd_sweep, (DWELL > 0)};

  assign cmd_ready  = 1'b1;
  assign sweep_busy = 1'b0;
  assign sweep_done = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= PERIOD_W'(RESET_PERIOD);
        duty_q[i]   <= DUTY_W'(RESET_DUTY);
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
      end
    end
  end

  assign period0 = period_q[0];
  assign period1 = period_q[1];
  assign period2 = period_q[2];
  assign period3 = period_q[3];
  assign duty0   = duty_q[0];
  assign duty1   = duty_q[1];
  assign duty2   = duty_q[2];
  assign duty3   = duty_q[3];

endmodule

// File: tb/tb_clock_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_sweep_ctrl
// Directed bench for clock_sweep_ctrl: reset values, a table of back-to-back
// static writes with clamp corner cases, and hand-written sequences for sweep
// timing, the 15 cap, abort, handshake hold and asynchronous reset mid-sweep.
// Sweep expectations are selected by CLOCK_SWEEP_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_clock_sweep_ctrl;

  localparam int DW = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_ch = '0;
  logic [11:0] cmd_period = '0;
  logic [3:0]  cmd_duty = '0;
  logic        cmd_sweep = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] period0, period1, period2, period3;
  logic [3:0]  duty0, duty1, duty2, duty3;
  logic        sweep_busy, sweep_done;

  clock_sweep_ctrl #(.DWELL(DW), .RESET_PERIOD(3), .RESET_DUTY(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_period (cmd_period),
    .cmd_duty   (cmd_duty),
    .cmd_sweep  (cmd_sweep),
    .abort      (abort),
    .period0    (period0),
    .period1    (period1),
    .period2    (period2),
    .period3    (period3),
    .duty0      (duty0),
    .duty1      (duty1),
    .duty2      (duty2),
    .duty3      (duty3),
    .sweep_busy (sweep_busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_p [4];
  logic [3:0]  exp_d [4];
  logic [11:0] act_p [4];
  logic [3:0]  act_d [4];

  assign act_p[0] = period0;
  assign act_p[1] = period1;
  assign act_p[2] = period2;
  assign act_p[3] = period3;
  assign act_d[0] = duty0;
  assign act_d[1] = duty1;
  assign act_d[2] = duty2;
  assign act_d[3] = duty3;

  typedef struct {
    logic [1:0]  ch;
    logic [11:0] p;
    logic [3:0]  d;
    logic [11:0] ep;
    logic [3:0]  ed;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s period%0d", tag, i), 32'(act_p[i]), 32'(exp_p[i]));
      chk($sformatf("%s duty%0d", tag, i), 32'(act_d[i]), 32'(exp_d[i]));
    end
  endtask

  task automatic check_flags(input string tag, input logic rdy, input logic busy, input logic done);
    chk($sformatf("%s cmd_ready", tag), 32'(cmd_ready), 32'(rdy));
    chk($sformatf("%s sweep_busy", tag), 32'(sweep_busy), 32'(busy));
    chk($sformatf("%s sweep_done", tag), 32'(sweep_done), 32'(done));
  endtask

  // Present one command for one cycle; returns at the negedge after the
  // accepting edge (sample index k=0).
  task automatic send(input logic [1:0] ch, input logic [11:0] p, input logic [3:0] d,
                      input logic sw);
    cmd_ch     = ch;
    cmd_period = p;
    cmd_duty   = d;
    cmd_sweep  = sw;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_sweep  = 1'b0;
  endtask

`ifdef CLOCK_SWEEP_EN
  // Each value other than the end value is held DW+1 cycles, the end value DW
  // cycles, then one done cycle; ready returns the cycle after done.
  task automatic run_sweep(input string tag, input logic [1:0] ch, input logic [11:0] p,
                           input logic [3:0] d, input int s, input int e);
    int done_k;
    int exp_duty;
    int step;
    done_k = (e - s) * (DW + 1) + DW;
    send(ch, p, d, 1'b1);
    exp_p[ch] = p;
    for (int k = 0; k <= done_k + 2; k++) begin
      step = k / (DW + 1);
      exp_duty = s + ((step < (e - s)) ? step : (e - s));
      chk($sformatf("%s k=%0d duty%0d", tag, k, ch), 32'(act_d[ch]), 32'(exp_duty));
      check_flags($sformatf("%s k=%0d", tag, k), k > done_k, k <= done_k, k == done_k);
      @(negedge clk);
    end
    exp_d[ch] = 4'(e);
    check_all({tag, " after"});
  endtask
`endif

  initial begin
    vecs[0] = '{ch: 2'd2, p: 12'd10,   d: 4'd4,  ep: 12'd10,   ed: 4'd4};
    vecs[1] = '{ch: 2'd0, p: 12'd0,    d: 4'd9,  ep: 12'd1,    ed: 4'd1};
    vecs[2] = '{ch: 2'd1, p: 12'd4095, d: 4'd15, ep: 12'd4095, ed: 4'd15};
    vecs[3] = '{ch: 2'd3, p: 12'd7,    d: 4'd8,  ep: 12'd7,    ed: 4'd7};
    vecs[4] = '{ch: 2'd3, p: 12'd15,   d: 4'd15, ep: 12'd15,   ed: 4'd15};
    vecs[5] = '{ch: 2'd0, p: 12'd2,    d: 4'd0,  ep: 12'd2,    ed: 4'd0};

    for (int i = 0; i < 4; i++) begin
      exp_p[i] = 12'd3;
      exp_d[i] = 4'd3;
    end

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check_all("reset held");
    rst = 1'b0;
    @(negedge clk);
    check_all("reset");
    check_flags("reset", 1'b1, 1'b0, 1'b0);

    // Back-to-back static writes, one per cycle.
    for (int i = 0; i < 6; i++) begin
      cmd_ch     = vecs[i].ch;
      cmd_period = vecs[i].p;
      cmd_duty   = vecs[i].d;
      cmd_sweep  = 1'b0;
      cmd_valid  = 1'b1;
      @(negedge clk);
      exp_p[vecs[i].ch] = vecs[i].ep;
      exp_d[vecs[i].ch] = vecs[i].ed;
      check_all($sformatf("static[%0d]", i));
      check_flags($sformatf("static[%0d]", i), 1'b1, 1'b0, 1'b0);
    end
    cmd_valid = 1'b0;

`ifdef CLOCK_SWEEP_EN
    // Sweep 1 -> 3 on channel 0: done 152 cycles after accept.
    run_sweep("sweep ch0", 2'd0, 12'd3, 4'd1, 1, 3);
    // Start 14, end capped at 15.
    run_sweep("sweep ch1", 2'd1, 12'd100, 4'd14, 14, 15);
    repeat (5) @(negedge clk);
    chk("ch1 stays 15", 32'(duty1), 32'd15);

    // Abort during the third dwell (duty 2 holds at k=102..152).
    send(2'd3, 12'd12, 4'd0, 1'b1);
    exp_p[3] = 12'd12;
    for (int k = 1; k <= 120; k++) @(negedge clk);
    chk("abort pre duty3", 32'(duty3), 32'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_d[3] = 4'd2;
    check_flags("abort next", 1'b1, 1'b0, 1'b0);
    check_all("abort next");
    for (int k = 0; k < 60; k++) begin
      if (sweep_done !== 1'b0 || duty3 !== 4'd2) begin
        chk($sformatf("abort quiet k=%0d", k), {27'd0, sweep_done, duty3}, 32'd2);
      end
      @(negedge clk);
    end
    chk("abort quiet duty3", 32'(duty3), 32'd2);

    // Handshake hold: a static command held through a 1-value sweep is
    // taken only once the controller is idle again (edge 52).
    cmd_ch = 2'd2; cmd_period = 12'd1; cmd_duty = 4'd1; cmd_sweep = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    exp_p[2] = 12'd1;
    exp_d[2] = 4'd1;
    cmd_ch = 2'd0; cmd_period = 12'd20; cmd_duty = 4'd5; cmd_sweep = 1'b0;
    for (int k = 0; k <= 52; k++) begin
      if (k == 52) begin
        exp_p[0] = 12'd20;
        exp_d[0] = 4'd5;
      end
      if (k == 0 || k == 25 || k == 50 || k == 51 || k == 52) begin
        check_all($sformatf("hold k=%0d", k));
        check_flags($sformatf("hold k=%0d", k), k >= 51, k <= 50, k == 50);
      end
      if (k < 52) @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check_flags("hold idle", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a sweep.
    send(2'd0, 12'd8, 4'd2, 1'b1);
    repeat (20) @(negedge clk);
    chk("pre-reset busy", 32'(sweep_busy), 32'd1);
`else
    // Without the sweep feature a sweep command is just a static write.
    send(2'd1, 12'd9, 4'd6, 1'b1);
    exp_p[1] = 12'd9;
    exp_d[1] = 4'd6;
    for (int k = 0; k < 5; k++) begin
      check_all($sformatf("nosweep k=%0d", k));
      check_flags($sformatf("nosweep k=%0d", k), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    send(2'd0, 12'd8, 4'd2, 1'b1);
    repeat (2) @(negedge clk);
`endif

    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_p[i] = 12'd3;
      exp_d[i] = 4'd3;
    end
    check_all("async reset");
    check_flags("async reset", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all("post reset");
    check_flags("post reset", 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_sweep_ctrl.md
# clock_sweep_ctrl

Configuration controller for the four-channel programmable clock generator (`clocks`). It accepts period/duty commands over a valid/ready handshake and drives the generator's `period0..3` and `duty0..3` inputs from registers. It also runs a timed duty-cycle sweep on one channel at a time, stepping duty at a fixed dwell interval, so characterization runs need no testbench-side sequencing.

## Interface
Parameters:
- `DWELL`, 50: clock cycles each sweep step is held (≥1).
- `RESET_PERIOD`, 3: reset value of all four period outputs.
- `RESET_DUTY`, 3: reset value of all four duty outputs.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_ch` in 2: target channel, 0–3.
- `cmd_period` in 12: requested period.
- `cmd_duty` in 4: requested duty, or the sweep start duty.
- `cmd_sweep` in 1: 0 = static write, 1 = start a duty sweep.
- `abort` in 1: terminate an active sweep.
- `period0..period3` out 12 each: to the generator.
- `duty0..duty3` out 4 each: to the generator.
- `sweep_busy` out 1: a sweep is active.
- `sweep_done` out 1: one-cycle pulse when a sweep completes normally.

## Operation
- **Reset** (asynchronous, `rst`=1):
  - All `periodN` = `RESET_PERIOD`; all `dutyN` = `RESET_DUTY`.
  - `cmd_ready`=1; `sweep_busy`=0; `sweep_done`=0.
  - State = IDLE.
  - Assertion mid-sweep abandons the sweep immediately. No done pulse is produced.
- **Accept rule:** a command is accepted when `cmd_valid && cmd_ready`. `cmd_ready` is 1 only in state IDLE.
- **Period clamp:** `p = (cmd_period==0) ? 1 : cmd_period`.
- **Duty clamp:** `d = min(cmd_duty, p)`. Compare at 12 bits, with duty zero-extended.
- **Static write:**
  - `periodN`←`p` and `dutyN`←`d` for the target channel.
  - Other channels are unchanged.
  - State stays IDLE.
- **Sweep:**
  - Latch channel and `p`. Compute end = `min(15, p)`.
  - `periodN`←`p` and `dutyN`←`d`. Go to DWELL with the dwell counter = `DWELL-1`.
- **FSM states:**
  - **IDLE:** waits for a command; `cmd_ready`=1.
  - **DWELL:** decrement the counter each cycle. When the counter is 0:
    - if `dutyN`==end, go to DONE;
    - otherwise go to STEP.
  - **STEP:** `dutyN`←`dutyN`+1; reload the counter to `DWELL-1`; go to DWELL. Duty never exceeds end, so the 4-bit value cannot wrap.
  - **DONE:** `sweep_done`=1 for this one cycle; go to IDLE.
- `sweep_busy`=1 in DWELL, STEP and DONE.
- **Abort:**
  - `abort`=1 in DWELL or STEP goes to IDLE on the next edge.
  - The current `dutyN` value is kept. No `sweep_done` pulse.
  - `abort` in IDLE or DONE is ignored.
- **Abort and step on the same edge:** abort wins; the step is not applied.
- **Start duty already at or above end:** duty is clamped to end, held for `DWELL` cycles, then DONE.

## Timing
- **Static write:** outputs update on the edge that accepts the command (1-cycle latency from the `cmd_valid` sample). Back-to-back static writes are accepted every cycle.
- **Sweep from start value s to end e:**
  - Each value holds for `DWELL` cycles. Each STEP adds 1 cycle, so values other than e are held `DWELL`+1 cycles.
  - `sweep_done` asserts `(e-s)*(DWELL+1)+DWELL` cycles after the accept edge.
  - `cmd_ready` returns 1 the cycle after `sweep_done`.
- All outputs are registered. There are no combinational input-to-output paths except `cmd_ready`, which decodes directly from state.

## Configuration
- **`CLOCK_SWEEP_EN` defined:** behaviour as above.
- **`CLOCK_SWEEP_EN` undefined:**
  - The DWELL, STEP and DONE states, the dwell counter and the `abort` logic are removed.
  - `cmd_sweep` is ignored; every command is a static write.
  - `sweep_busy`=0 and `sweep_done`=0 constantly; `cmd_ready`=1 constantly.

## Structure
- **Package `clock_cfg_pkg`:**
  - `PERIOD_W`=12, `DUTY_W`=4, `NCH`=4, `DUTY_MAX`=15.
  - State enum: IDLE, DWELL, STEP, DONE.
  - Channel output registers are held as arrays indexed by channel and fanned out to the named ports.
- **Sub-module `dwell_timer`:** loadable down-counter with a zero flag. It is instantiated only under `CLOCK_SWEEP_EN`.

## Test plan
- **Reset:** assert `rst` at t=0 for 3 cycles.
  - All periods = 3, all duties = 3, `cmd_ready`=1.
  - Then assert `rst` asynchronously mid-cycle during a sweep: outputs return to reset values before the next edge.
- **Static writes:**
  - ch2, period 10, duty 4, `cmd_sweep`=0 → `period2`=10, `duty2`=4 on the next edge; channels 0, 1 and 3 unchanged.
  - period 0, duty 9 → period 1, duty 1.
- **Sweep, `DWELL`=50:** ch0, period 3, duty 1, sweep.
  - `duty0` sequence: 1 (51 cycles), 2 (51 cycles), 3 (50 cycles).
  - `sweep_done` pulses 152 cycles after accept; `cmd_ready` is 0 throughout.
- **Sweep clamped at 15:** ch1, period 100, duty 14 → `duty1` 14 then 15; done; `duty1` stays 15.
- **Abort:** start a sweep on ch3 at duty 0; assert `abort` during the 3rd dwell.
  - `duty3` stays 2; IDLE on the next cycle; no `sweep_done`.
- **Handshake hold:** `cmd_valid` held high during a sweep → the command is not accepted until IDLE, then it is taken exactly once.
